// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: PC loop, instruction memory read port, decode handshake and redirect.
// master = fetch_unit, slave = the surrounding pc_module / memory / decode environment.
interface fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcNext;
    logic             memReq;
    logic [WIDTH-1:0] memAddr;
    logic             memReady;
    logic [WIDTH-1:0] memData;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instrPc;
    logic             instrValid;
    logic             instrAccept;
    logic             redirect;
    logic [WIDTH-1:0] redirectTarget;

    modport master (
        input  pc,
        output pcNext,
        output memReq,
        output memAddr,
        input  memReady,
        input  memData,
        output instr,
        output instrPc,
        output instrValid,
        input  instrAccept,
        input  redirect,
        input  redirectTarget
    );

    modport slave (
        output pc,
        input  pcNext,
        input  memReq,
        input  memAddr,
        output memReady,
        output memData,
        input  instr,
        input  instrPc,
        input  instrValid,
        output instrAccept,
        output redirect,
        output redirectTarget
    );
endinterface

// File: rtl/fetch_unit.sv
// Two-state fetch sequencer: FETCH issues a read at pc, HOLD presents the word to decode.
// pcNext is combinational and feeds an external PC register that loads every edge.
module fetch_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic              clk,
    input logic              reset,
    fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [WIDTH-1:0] pc_next;
    logic             mem_req;
    logic             instr_valid;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        pc_next     = bus.pc;
        mem_req     = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.redirect) begin
                    pc_next = bus.redirectTarget;
                end else if (bus.memReady) begin
                    instr_d    = bus.memData;
                    instr_pc_d = bus.pc;
                    pc_next    = bus.pc + WIDTH'(1);
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                // Redirect wins over accept: the held word is squashed, not delivered.
                if (bus.redirect) begin
                    pc_next = bus.redirectTarget;
                    state_d = ST_FETCH;
                end else if (bus.instrAccept) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (reset) begin
            pc_next = RESET_VECTOR;
            mem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.pcNext     = pc_next;
    assign bus.memReq     = mem_req;
    assign bus.memAddr    = bus.pc;
    assign bus.instr      = instr_q;
    assign bus.instrPc    = instr_pc_q;
    assign bus.instrValid = instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table for the multi-cycle scenarios, then
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_unit;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] RV = 16'h0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if #(.WIDTH(WIDTH)) bus ();

    fetch_unit #(.WIDTH(WIDTH), .RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for pc_module: loads pcNext on every edge.
    always @(posedge clk) bus.pc <= bus.pcNext;

    typedef struct {
        logic        rst, rdy, acc, rdr;
        logic [15:0] data, tgt;
        logic [15:0] pc, pcn;
        logic        req, vld;
        logic [15:0] ins, ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic rdy, logic [15:0] data, logic acc,
                                logic rdr, logic [15:0] tgt, logic [15:0] pc,
                                logic [15:0] pcn, logic req, logic vld,
                                logic [15:0] ins, logic [15:0] ipc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.data = data; v.acc = acc; v.rdr = rdr; v.tgt = tgt;
        v.pc = pc; v.pcn = pcn; v.req = req; v.vld = vld; v.ins = ins; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic [15:0] data,
                         input logic acc, input logic rdr, input logic [15:0] tgt);
        reset              = rst;
        bus.memReady       = rdy;
        bus.memData        = data;
        bus.instrAccept    = acc;
        bus.redirect       = rdr;
        bus.redirectTarget = tgt;
    endtask

    task automatic check_all(input logic [15:0] pc, input logic [15:0] pcn, input logic req,
                             input logic vld, input logic [15:0] ins, input logic [15:0] ipc);
        chk("pc",         bus.pc,                 pc);
        chk("pcNext",     bus.pcNext,             pcn);
        chk("memReq",     {15'd0, bus.memReq},    {15'd0, req});
        chk("memAddr",    bus.memAddr,            pc);
        chk("instrValid", {15'd0, bus.instrValid}, {15'd0, vld});
        chk("instr",      bus.instr,              ins);
        chk("instrPc",    bus.instrPc,            ipc);
    endtask

    // Reference model state: what decode should see, and the PC pc_module should hold.
    logic        m_hold;
    logic [15:0] m_pc, m_instr, m_ipc;

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    initial begin
        int delivered = 0;
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;

        //          rst rdy data      acc rdr tgt        pc        pcNext   req vld instr     instrPc
        tbl.push_back(mk(1, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 1, 16'h1000, 1, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 1, 16'h1001, 1, 0, 16'h0000, 16'h0001, 16'h0001, 0, 1, 16'h1000, 16'h0000));
        tbl.push_back(mk(0, 1, 16'h1001, 1, 0, 16'h0000, 16'h0001, 16'h0002, 1, 0, 16'h1000, 16'h0000));
        tbl.push_back(mk(0, 1, 16'h1002, 1, 0, 16'h0000, 16'h0002, 16'h0002, 0, 1, 16'h1001, 16'h0001));
        tbl.push_back(mk(0, 1, 16'h1002, 1, 0, 16'h0000, 16'h0002, 16'h0003, 1, 0, 16'h1001, 16'h0001));
        tbl.push_back(mk(0, 1, 16'h1003, 1, 0, 16'h0000, 16'h0003, 16'h0003, 0, 1, 16'h1002, 16'h0002));
        tbl.push_back(mk(0, 1, 16'h1003, 1, 0, 16'h0000, 16'h0003, 16'h0004, 1, 0, 16'h1002, 16'h0002));
        tbl.push_back(mk(0, 1, 16'h1004, 1, 0, 16'h0000, 16'h0004, 16'h0004, 0, 1, 16'h1003, 16'h0003));
        tbl.push_back(mk(0, 1, 16'h1004, 1, 0, 16'h0000, 16'h0004, 16'h0005, 1, 0, 16'h1003, 16'h0003));
        tbl.push_back(mk(0, 1, 16'h1005, 1, 0, 16'h0000, 16'h0005, 16'h0005, 0, 1, 16'h1004, 16'h0004));
        // wait states at pc=0005
        tbl.push_back(mk(0, 0, 16'h1111, 0, 0, 16'h0000, 16'h0005, 16'h0005, 1, 0, 16'h1004, 16'h0004));
        tbl.push_back(mk(0, 0, 16'h2222, 1, 0, 16'h0000, 16'h0005, 16'h0005, 1, 0, 16'h1004, 16'h0004));
        tbl.push_back(mk(0, 0, 16'h3333, 0, 0, 16'h0000, 16'h0005, 16'h0005, 1, 0, 16'h1004, 16'h0004));
        tbl.push_back(mk(0, 1, 16'hBEEF, 0, 0, 16'h0000, 16'h0005, 16'h0006, 1, 0, 16'h1004, 16'h0004));
        // decode stall: four cycles without accept, memReady ignored
        tbl.push_back(mk(0, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0006, 16'h0006, 0, 1, 16'hBEEF, 16'h0005));
        tbl.push_back(mk(0, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0006, 16'h0006, 0, 1, 16'hBEEF, 16'h0005));
        tbl.push_back(mk(0, 0, 16'hAAAA, 0, 0, 16'h0000, 16'h0006, 16'h0006, 0, 1, 16'hBEEF, 16'h0005));
        tbl.push_back(mk(0, 1, 16'hAAAA, 0, 0, 16'h0000, 16'h0006, 16'h0006, 0, 1, 16'hBEEF, 16'h0005));
        tbl.push_back(mk(0, 1, 16'hAAAA, 1, 0, 16'h0000, 16'h0006, 16'h0006, 0, 1, 16'hBEEF, 16'h0005));
        tbl.push_back(mk(0, 1, 16'h2006, 0, 0, 16'h0000, 16'h0006, 16'h0007, 1, 0, 16'hBEEF, 16'h0005));
        // redirect with simultaneous accept in HOLD
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0040, 16'h0007, 16'h0040, 0, 1, 16'h2006, 16'h0006));
        tbl.push_back(mk(0, 1, 16'h3040, 0, 0, 16'h0000, 16'h0040, 16'h0041, 1, 0, 16'h2006, 16'h0006));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0041, 16'h0041, 0, 1, 16'h3040, 16'h0040));
        // redirect in FETCH with memReady=1: data dropped
        tbl.push_back(mk(0, 1, 16'hDEAD, 0, 1, 16'h1234, 16'h0041, 16'h1234, 1, 0, 16'h3040, 16'h0040));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h1234, 16'h1234, 1, 0, 16'h3040, 16'h0040));
        // wrap at FFFF
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'hFFFF, 16'h1234, 16'hFFFF, 1, 0, 16'h3040, 16'h0040));
        tbl.push_back(mk(0, 1, 16'h7FFF, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 16'h3040, 16'h0040));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h7FFF, 16'hFFFF));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h7FFF, 16'hFFFF));
        tbl.push_back(mk(0, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 16'h0001, 1, 0, 16'h7FFF, 16'hFFFF));
        // reset while holding
        tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 16'h0000, 16'h0001, 16'h0000, 0, 1, 16'h1111, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].data, tbl[i].acc, tbl[i].rdr, tbl[i].tgt);
            @(negedge clk);
            $display("vec %0d pc=%h pcNext=%h req=%b valid=%b instr=%h instrPc=%h",
                     i, bus.pc, bus.pcNext, bus.memReq, bus.instrValid, bus.instr, bus.instrPc);
            check_all(tbl[i].pc, tbl[i].pcn, tbl[i].req, tbl[i].vld, tbl[i].ins, tbl[i].ipc);
            @(posedge clk);
            #1;
        end

        // Last vector left the unit in FETCH at pc 0000 with cleared instruction registers.
        m_hold = 1'b0; m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;

        for (int n = 0; n < 400; n++) begin
            logic        rst, rdy, acc, rdr;
            logic [15:0] tgt, data, e_pcn;
            logic        e_req;
            rst  = ($urandom_range(0, 39) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            acc  = ($urandom_range(0, 2) != 0);
            rdr  = ($urandom_range(0, 7) == 0);
            tgt  = (n % 50 == 7) ? 16'hFFFF : 16'($urandom);
            data = rdy ? mem_word(bus.pc) : 16'($urandom);
            drive(rst, rdy, data, acc, rdr, tgt);

            if (rst) begin
                e_pcn = RV;
                e_req = 1'b0;
            end else if (!m_hold) begin
                e_req = 1'b1;
                e_pcn = rdr ? tgt : (rdy ? m_pc + 16'd1 : m_pc);
            end else begin
                e_req = 1'b0;
                e_pcn = rdr ? tgt : m_pc;
            end

            @(negedge clk);
            check_all(m_pc, e_pcn, e_req, m_hold, m_instr, m_ipc);

            if (rst) begin
                m_hold = 1'b0; m_instr = 16'h0000; m_ipc = 16'h0000;
            end else if (!m_hold) begin
                if (!rdr && rdy) begin
                    m_hold = 1'b1; m_instr = mem_word(m_pc); m_ipc = m_pc;
                end
            end else if (rdr || acc) begin
                if (!rdr) begin
                    delivered++;
                    $display("deliver %0d instrPc=%h instr=%h", delivered, m_ipc, m_instr);
                end
                m_hold = 1'b0;
            end
            m_pc = e_pcn;
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer that closes the loop around pc_module.
- Consumes the registered `pc` and drives `pcNext` back into it every cycle.
- Issues a word read to instruction memory at `pc` and hands the returned instruction to decode through a valid/accept handshake.
- Redirects to a branch target on request, squashing any instruction in flight.

Parameters:
- WIDTH, 16, width of pc, addresses and instruction words.
- RESET_VECTOR, 16'h0000, PC value loaded while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  WIDTH  current PC from pc_module.
- pcNext  output  WIDTH  next PC to pc_module; combinational, loaded by pc_module every edge.
- memReq  output  1  instruction read request.
- memAddr  output  WIDTH  word address of the request; equals pc.
- memReady  input  1  memory has memData valid for memAddr this cycle.
- memData  input  WIDTH  instruction word from memory.
- instr  output  WIDTH  fetched instruction (registered).
- instrPc  output  WIDTH  address instr was fetched from (registered).
- instrValid  output  1  instr/instrPc valid for decode.
- instrAccept  input  1  decode consumes instr this cycle.
- redirect  input  1  branch/jump taken; discard current fetch/instruction.
- redirectTarget  input  WIDTH  new PC when redirect=1.

Behaviour:
- Reset:
  - Synchronous and active-high; takes precedence over everything, including mid-fetch or mid-hold.
  - While reset=1: pcNext=RESET_VECTOR, memReq=0.
  - At the edge: instrValid<=0, instr<=0, instrPc<=0, state<=FETCH.
  - First cycle after release: pc==RESET_VECTOR, memReq=1.
- pc_module has no hold input, so pcNext must equal pc whenever the PC is to be held.
- Word addressing: increment is +1, modulo 2^WIDTH. 16'hFFFF+1 = 16'h0000, no flag.
- States:
  - FETCH: memReq=1, memAddr=pc, instrValid=0.
    - redirect=1 → pcNext=redirectTarget, stay FETCH; memData ignored even if memReady=1.
    - else memReady=1 → instr<=memData, instrPc<=pc, pcNext=pc+1, go HOLD.
    - else → pcNext=pc, stay FETCH. memAddr may change only via redirect; memory tolerates request abandonment.
  - HOLD: memReq=0, instrValid=1, instr/instrPc stable.
    - redirect=1 → pcNext=redirectTarget, instrValid<=0, go FETCH. Redirect beats instrAccept in the same cycle; the instruction counts as squashed, not delivered.
    - else instrAccept=1 → pcNext=pc, go FETCH.
    - else → pcNext=pc, stay HOLD.
- Latency:
  - With zero-wait memory (memReady=1 in the request cycle), instrValid rises 1 cycle after FETCH entry.
  - Peak throughput is 1 instruction per 2 cycles when decode accepts immediately.
- instrAccept or memReady asserted in a state that does not use them is ignored.
- redirect is sampled every non-reset cycle; it has effect in both states.
- An undefined state encoding recovers to FETCH with instrValid=0.

Test Plan:
- Reset release, memReady=1 always, instrAccept=1 always, memData=16'h1000+addr:
  - pcNext sequence after release is 0001, 0001, 0002, 0002, …
  - instr = 1000, 1001, 1002 with instrPc = 0000, 0001, 0002.
  - instrValid toggles 0,1,0,1.
- Wait states: memReady held 0 for 3 cycles at pc=0005, then 1 with memData=16'hBEEF:
  - memReq=1 and pcNext=0005 throughout the wait.
  - Then instr=BEEF, instrPc=0005, and pc becomes 0006.
- Decode stall: hold instrAccept=0 for 4 cycles in HOLD:
  - instrValid stays 1, instr unchanged, memReq=0, pc stays put.
  - Accept on cycle 5 → FETCH at the same pc.
- Redirect with simultaneous instrAccept in HOLD, redirectTarget=16'h0040:
  - instrValid=0 next cycle, pc=0040.
  - The next delivered instrPc is 0040.
- Redirect during FETCH with memReady=1 in the same cycle, redirectTarget=16'h1234:
  - memData is dropped, instrValid stays 0, pc=1234.
  - Next memAddr=1234.
- Wrap: start at pc=16'hFFFF, zero-wait memory → instrPc=FFFF delivered, then memAddr=0000.
- Mid-operation reset: assert reset during HOLD → next cycle instrValid=0, pc=RESET_VECTOR.
